ov7670_capture: RTL
===================

# ov7670_capture

Camera-side capture stage for the 320×240 RGB565 frame buffer. It samples the OV7670 byte stream (vsync, href, 8-bit data) on the camera pixel clock and packs byte pairs into 16-bit RGB565 words. It generates the linear write address and write strobe for the frame buffer's write port. The display-side reader, which upscales and mirrors, consumes the same buffer through its read port.

## Interface
Parameters:
- IMG_W, 320, active pixels per line written to the buffer
- IMG_H, 240, active lines per frame written to the buffer

Ports:
- clk  in  1  camera PCLK; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  camera VSYNC, high during vertical blanking
- href  in  1  camera HREF, high while line bytes are valid
- data  in  8  camera byte bus
- enable  in  1  capture enable, sampled at frame start
- we  out  1  frame buffer write strobe, one cycle per pixel
- wAddr  out  $clog2(IMG_W*IMG_H)  linear address, y*IMG_W + x
- wData  out  16  RGB565 pixel, first byte in [15:8]
- frame_done  out  1  one-cycle pulse at end of a captured frame
- busy  out  1  high while in CAPTURE
- line_err  out  1  set when any line of the current frame has a length other than 2*IMG_W bytes

## Operation
- State machine with three states: IDLE, SYNC, CAPTURE.
  - IDLE: wait for vsync=1, then go to SYNC.
  - SYNC: wait for vsync=0. If enable=1, go to CAPTURE and clear x, y, line_base, byte phase and line_err. If enable=0, return to IDLE.
  - CAPTURE: on a vsync rising edge, pulse frame_done and go to SYNC.
- Byte phase, only while href=1:
  - Phase 0 latches data into hi_byte.
  - Phase 1 forms {hi_byte, data}.
  - Phase toggles on every href=1 cycle.
- Pixel write: on phase 1, with x<IMG_W and y<IMG_H:
  - Register we=1, wData and wAddr=line_base+x.
  - x increments on every completed pixel, saturating at IMG_W.
- Line end is the href falling edge (href_d=1, href=0). On line end:
  - If x≠IMG_W or phase=1, set line_err.
  - Discard any dangling byte.
  - Reset x and phase to 0.
  - Increment y; add IMG_W to line_base when y<IMG_H.
- Clipping:
  - Pixels beyond IMG_W and lines beyond IMG_H produce no write.
  - Addresses never exceed IMG_W*IMG_H-1.
- href activity outside CAPTURE is ignored.
- line_err holds its value until the next CAPTURE entry or reset.

## Timing
- Reset values: we=0, wAddr=0, wData=0, frame_done=0, busy=0, line_err=0, state=IDLE; all counters 0.
- Latency: second byte sampled at edge N; we/wAddr/wData valid in the cycle after edge N, held one cycle. we is never high on two consecutive cycles.
- frame_done is high for the cycle after the edge that samples vsync 0→1 in CAPTURE. busy falls in that same cycle.
- vsync rising mid-line ends the frame immediately; the partial line is not counted, and frame_done still pulses.
- enable changes mid-frame have no effect until the next SYNC→CAPTURE decision.
- Reset mid-frame forces the reset values at once. Capture resumes only after a full vsync high→low sequence, so a partial frame is never written after reset.
- No multiplier: line_base is an accumulator.

## Configuration
- FRAME_SKIP_EN defined:
  - A frame toggle flips on each CAPTURE entry.
  - we is suppressed on odd frames (the first frame after reset is captured), halving buffer write traffic.
  - frame_done, busy and line_err behave identically on skipped frames.
- FRAME_SKIP_EN undefined: every enabled frame is written.

## Test plan
- Full frame, 240 lines × 640 bytes, enable=1 → 76800 we pulses, wAddr 0…76799 in order, one frame_done after vsync rises, line_err=0.
- Line 0 bytes 0xF8, 0x1F → wData=0xF81F at wAddr=0, we high exactly one cycle after the 0x1F edge.
- Line 3 with 638 bytes → line_err=1, 319 writes for that line, line 4 begins at wAddr=1280.
- Line of 700 bytes and 250 lines → writes clipped to x<320 and y<240, max wAddr=76799.
- enable=0 at vsync fall → no we, busy=0 for the whole frame; enable=1 on the next frame → normal capture.
- reset_n pulsed low mid-line 100 → all outputs 0 immediately, no writes until after the next vsync high→low. With FRAME_SKIP_EN, two frames → writes only on the first, two frame_done pulses.

Source files
------------

// File: rtl/ov7670_capture.sv
// ============================================================================
// Module   : ov7670_capture
// Purpose  : OV7670 byte-stream capture. Packs byte pairs into RGB565 words
//            and drives the write port of a IMG_W x IMG_H frame buffer.
// Options  : FRAME_SKIP_EN - when defined, only every other captured frame
//            is written; the first frame after reset is written.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ov7670_capture #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  localparam int AW   = $clog2(IMG_W * IMG_H)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    data,
  input  logic          enable,
  output logic          we,
  output logic [AW-1:0] wAddr,
  output logic [15:0]   wData,
  output logic          frame_done,
  output logic          busy,
  output logic          line_err
);

  // x saturates at IMG_W, y at IMG_H, line_base reaches IMG_W*IMG_H
  localparam int XW  = $clog2(IMG_W + 1);
  localparam int YW  = $clog2(IMG_H + 1);
  localparam int LBW = $clog2(IMG_W * IMG_H + 1);

  localparam logic [XW-1:0]  X_END   = XW'(IMG_W);
  localparam logic [YW-1:0]  Y_END   = YW'(IMG_H);
  localparam logic [LBW-1:0] LB_STEP = LBW'(IMG_W);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            start_cap;
  logic            frame_end;
  logic            write_ok;

  logic            vsync_d;
  logic            href_d;
  logic            phase;
  logic [7:0]      hi_byte;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic [LBW-1:0]  line_base;

  assign busy = (state == CAPTURE);

`ifdef FRAME_SKIP_EN
  logic frame_odd;

  // Frame parity flips on every CAPTURE entry; reset value makes frame 0 even
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_odd <= 1'b1;
    end else if (start_cap) begin
      frame_odd <= ~frame_odd;
    end
  end

  assign write_ok = ~frame_odd;
`else
  assign write_ok = 1'b1;
`endif

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; enable only matters at the SYNC->CAPTURE decision
  always_comb begin
    state_next = state;
    start_cap  = 1'b0;
    frame_end  = 1'b0;
    case (state)
      IDLE: begin
        if (vsync) begin
          state_next = SYNC;
        end
      end
      SYNC: begin
        if (!vsync) begin
          if (enable) begin
            state_next = CAPTURE;
            start_cap  = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      CAPTURE: begin
        if (vsync && !vsync_d) begin
          state_next = SYNC;
          frame_end  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Byte pairing, pixel writes, line accounting; frame end wins over line end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_d    <= 1'b0;
      href_d     <= 1'b0;
      phase      <= 1'b0;
      hi_byte    <= '0;
      x          <= '0;
      y          <= '0;
      line_base  <= '0;
      we         <= 1'b0;
      wAddr      <= '0;
      wData      <= '0;
      frame_done <= 1'b0;
      line_err   <= 1'b0;
    end else begin
      vsync_d    <= vsync;
      href_d     <= href;
      we         <= 1'b0;
      frame_done <= 1'b0;
      if (start_cap) begin
        x         <= '0;
        y         <= '0;
        line_base <= '0;
        phase     <= 1'b0;
        line_err  <= 1'b0;
      end else if (frame_end) begin
        frame_done <= 1'b1;
      end else if (state == CAPTURE) begin
        if (href) begin
          if (!phase) begin
            hi_byte <= data;
            phase   <= 1'b1;
          end else begin
            phase <= 1'b0;
            if (x < X_END) begin
              if (y < Y_END) begin
                we    <= write_ok;
                wData <= {hi_byte, data};
                wAddr <= AW'(line_base + LBW'(x));
              end
              x <= x + 1'b1;
            end
          end
        end else if (href_d) begin
          if ((x != X_END) || phase) begin
            line_err <= 1'b1;
          end
          x     <= '0;
          phase <= 1'b0;
          if (y < Y_END) begin
            y         <= y + 1'b1;
            line_base <= line_base + LB_STEP;
          end
        end
      end
    end
  end

endmodule

`default_nettype wire
